// File: rtl/exec_stage_if.sv
// D->E operands and controls into the execute stage, and its E->M register,
// condition codes and bypass values out of it.
interface exec_stage_if #(
    parameter int WIDTH = 64,
    parameter int REGW  = 4
);
    logic             e_valid;
    logic [3:0]       e_icode;
    logic [3:0]       e_ifun;
    logic [WIDTH-1:0] e_valA;
    logic [WIDTH-1:0] e_valB;
    logic [WIDTH-1:0] e_valC;
    logic [REGW-1:0]  e_dstE;
    logic [REGW-1:0]  e_dstM;
    logic             set_cc_en;
    logic             stall;
    logic             bubble;
    logic [WIDTH-1:0] fwd_valE;
    logic [REGW-1:0]  fwd_dstE;
    logic             m_valid;
    logic [3:0]       m_icode;
    logic             m_cnd;
    logic [WIDTH-1:0] m_valE;
    logic [WIDTH-1:0] m_valA;
    logic [REGW-1:0]  m_dstE;
    logic [REGW-1:0]  m_dstM;
    logic             m_err;
    logic [2:0]       cc;

    modport master (
        output e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
               set_cc_en, stall, bubble,
        input  fwd_valE, fwd_dstE, m_valid, m_icode, m_cnd, m_valE, m_valA,
               m_dstE, m_dstM, m_err, cc
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, e_valA, e_valB, e_valC, e_dstE, e_dstM,
               set_cc_en, stall, bubble,
        output fwd_valE, fwd_dstE, m_valid, m_icode, m_cnd, m_valE, m_valA,
               m_dstE, m_dstM, m_err, cc
    );
endinterface

// File: rtl/exec_stage.sv
// Y86-64 pipelined execute stage: ALU, branch/cmov condition, condition-code
// register and the E->M pipeline register with stall/bubble control.
module exec_stage #(
    parameter int              WIDTH = 64,
    parameter int              REGW  = 4,
    parameter logic [REGW-1:0] RNONE = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    exec_stage_if.slave   bus
);
    localparam logic [WIDTH-1:0] EIGHT   = WIDTH'(8);
    localparam logic [3:0]       I_NOP   = 4'h1;
    localparam logic [2:0]       CC_INIT = 3'b100;

    logic [WIDTH-1:0] val_e;
    logic             alu_err;
    logic             cnd;
    logic             cc_we;
    logic [2:0]       cc_new;
    logic [REGW-1:0]  eff_dst_e;
    logic             sign_a, sign_b, sign_v;
    logic             zf, sf, of;

    logic             m_valid_q, m_valid_d;
    logic [3:0]       m_icode_q, m_icode_d;
    logic             m_cnd_q, m_cnd_d;
    logic [WIDTH-1:0] m_val_e_q, m_val_e_d;
    logic [WIDTH-1:0] m_val_a_q, m_val_a_d;
    logic [REGW-1:0]  m_dst_e_q, m_dst_e_d;
    logic [REGW-1:0]  m_dst_m_q, m_dst_m_d;
    logic             m_err_q, m_err_d;
    logic [2:0]       cc_q, cc_d;

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        val_e   = '0;
        alu_err = 1'b0;
        case (bus.e_icode)
            4'h2:       val_e = bus.e_valA;
            4'h3:       val_e = bus.e_valC;
            4'h4, 4'h5: val_e = bus.e_valB + bus.e_valC;
            4'h6: begin
                case (bus.e_ifun)
                    4'h0:    val_e = bus.e_valB + bus.e_valA;
                    4'h1:    val_e = bus.e_valB - bus.e_valA;
                    4'h2:    val_e = bus.e_valB & bus.e_valA;
                    4'h3:    val_e = bus.e_valB ^ bus.e_valA;
                    default: alu_err = 1'b1;
                endcase
            end
            4'h8, 4'hA: val_e = bus.e_valB - EIGHT;
            4'h9, 4'hB: val_e = bus.e_valB + EIGHT;
            default:    val_e = '0;
        endcase
    end

    assign sign_a = bus.e_valA[WIDTH-1];
    assign sign_b = bus.e_valB[WIDTH-1];
    assign sign_v = val_e[WIDTH-1];

    // Overflow only exists for add/sub; sub computes valB-valA.
    always_comb begin
        cc_new = {(val_e == '0), sign_v, 1'b0};
        if (bus.e_ifun == 4'h0)
            cc_new[0] = (sign_a == sign_b) && (sign_v != sign_a);
        else if (bus.e_ifun == 4'h1)
            cc_new[0] = (sign_a != sign_b) && (sign_v != sign_b);
    end

    // Condition uses the CC as it stands before this cycle's update.
    always_comb begin
        cnd = 1'b0;
        if (bus.e_icode == 4'h7 || bus.e_icode == 4'h2) begin
            case (bus.e_ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf ^ of) | zf;
                4'h2:    cnd = sf ^ of;
                4'h3:    cnd = zf;
                4'h4:    cnd = !zf;
                4'h5:    cnd = !(sf ^ of);
                4'h6:    cnd = !(sf ^ of) && !zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign eff_dst_e = (bus.e_icode == 4'h2 && !cnd) ? RNONE : bus.e_dstE;
    assign cc_we     = bus.e_valid && (bus.e_icode == 4'h6) && (bus.e_ifun <= 4'h3)
                       && bus.set_cc_en && !bus.stall && !bus.bubble;

    assign bus.fwd_valE = val_e;
    assign bus.fwd_dstE = (!bus.e_valid || bus.bubble) ? RNONE : eff_dst_e;

    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_val_e_d = m_val_e_q;
        m_val_a_d = m_val_a_q;
        m_dst_e_d = m_dst_e_q;
        m_dst_m_d = m_dst_m_q;
        m_err_d   = m_err_q;
        cc_d      = cc_we ? cc_new : cc_q;
        if (!bus.stall) begin
            if (bus.bubble || !bus.e_valid) begin
                m_valid_d = 1'b0;
                m_icode_d = I_NOP;
                m_cnd_d   = 1'b0;
                m_val_e_d = '0;
                m_val_a_d = '0;
                m_dst_e_d = RNONE;
                m_dst_m_d = RNONE;
                m_err_d   = 1'b0;
            end else begin
                m_valid_d = 1'b1;
                m_icode_d = bus.e_icode;
                m_cnd_d   = cnd;
                m_val_e_d = val_e;
                m_val_a_d = bus.e_valA;
                m_dst_e_d = eff_dst_e;
                m_dst_m_d = bus.e_dstM;
                m_err_d   = alu_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_val_e_q <= '0;
            m_val_a_q <= '0;
            m_dst_e_q <= RNONE;
            m_dst_m_q <= RNONE;
            m_err_q   <= 1'b0;
            cc_q      <= CC_INIT;
        end else begin
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_val_e_q <= m_val_e_d;
            m_val_a_q <= m_val_a_d;
            m_dst_e_q <= m_dst_e_d;
            m_dst_m_q <= m_dst_m_d;
            m_err_q   <= m_err_d;
            cc_q      <= cc_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_icode = m_icode_q;
    assign bus.m_cnd   = m_cnd_q;
    assign bus.m_valE  = m_val_e_q;
    assign bus.m_valA  = m_val_a_q;
    assign bus.m_dstE  = m_dst_e_q;
    assign bus.m_dstM  = m_dst_m_q;
    assign bus.m_err   = m_err_q;
    assign bus.cc      = cc_q;
endmodule
